// File: rtl/alu_resp_if.sv
// Request/response bus between the ALU stimulus side (master) and the ALU responder (slave).
// Two independent valid/ready channels plus a busy indication.
interface alu_resp_if #(
  parameter int WIDTH = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic [WIDTH-1:0] rsp_o;
  logic             busy;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_o, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_o, busy
  );
endinterface

// File: rtl/alu_resp.sv
// Handshaked ALU responder: single-cycle logic/arith ops, iterative MUL (shift-add) and DIV (restoring).
// state | meaning:  IDLE | ready for a request;  CALC | MUL/DIV iterating;  RESP | result presented
module alu_resp #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_resp_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] o_q, o_d;

  logic [WIDTH-1:0] sc_out, sc_o;
  logic             sc_c;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_new;
  logic             rem_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign add_w = {1'b0, bus.req_a} + {1'b0, bus.req_b};
  assign sub_w = {1'b0, bus.req_a} - {1'b0, bus.req_b};

  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    case (bus.req_sel)
      4'h0: begin sc_out = add_w[WIDTH-1:0]; sc_c = add_w[WIDTH]; end
      4'h1: begin sc_out = sub_w[WIDTH-1:0]; sc_c = sub_w[WIDTH]; end
      4'h4: sc_out = bus.req_a & bus.req_b;
      4'h5: sc_out = bus.req_a | bus.req_b;
      4'h6: sc_out = bus.req_a ^ bus.req_b;
      4'h7: sc_out = ~(bus.req_a & bus.req_b);
      4'h8: sc_out = ~(bus.req_a | bus.req_b);
      4'h9: sc_out = ~(bus.req_a ^ bus.req_b);
      4'hA: sc_out = bus.req_a << bus.req_b[2:0];
      4'hB: sc_out = bus.req_a >> bus.req_b[2:0];
      4'hC: sc_out = {bus.req_a[WIDTH-2:0], bus.req_a[WIDTH-1]};
      4'hD: sc_out = {bus.req_a[0], bus.req_a[WIDTH-1:1]};
      4'hE: sc_out = WIDTH'(bus.req_a > bus.req_b);
      4'hF: sc_out = bus.req_a;
      default: sc_out = '0;
    endcase
    sc_o    = '0;
    sc_o[1] = (sc_out == '0);
    sc_o[0] = sc_c;
  end

  // One iteration of MUL ({hi,lo} product, lo starts as B) or DIV (hi remainder, lo quotient).
  // A zero divisor always "fits", giving all-ones quotient and remainder A with no special case.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_new = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    if (div_q) begin
      step_hi = rem_new[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], rem_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    out_d   = out_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_sel == 4'h2 || bus.req_sel == 4'h3) begin
            state_d = CALC;
            cnt_d   = '0;
            div_d   = bus.req_sel[0];
            hi_d    = '0;
            opnd_d  = bus.req_sel[0] ? bus.req_b : bus.req_a;
            lo_d    = bus.req_sel[0] ? bus.req_a : bus.req_b;
          end else begin
            state_d = RESP;
            out_d   = sc_out;
            o_d     = sc_o;
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
          out_d   = step_lo;
          o_d     = step_hi;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      out_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      out_q   <= out_d;
      o_q     <= o_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_out   = out_q;
  assign bus.rsp_o     = o_q;
endmodule

// File: tb/tb_alu_resp.sv
// Bench for alu_resp: vector table, randomized ops against a reference model, backpressure and reset-abort sequences.
module tb_alu_resp;
  typedef struct {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [7:0] o;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic [7:0] o;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  exp_t sb[$];
  vec_t vecs[$];

  alu_resp_if #(.WIDTH(8)) bus ();
  alu_resp #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    exp_t e;
    logic [8:0]  s;
    logic [15:0] p;
    logic [2:0]  sh;
    logic        c;
    c = 1'b0;
    sh = b[2:0];
    e.o = 8'h00;
    e.lat = 1;
    case (sel)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; e.out = s[7:0]; c = s[8]; end
      4'h1: begin e.out = a - b; c = (a < b); end
      4'h4: e.out = a & b;
      4'h5: e.out = a | b;
      4'h6: e.out = a ^ b;
      4'h7: e.out = ~(a & b);
      4'h8: e.out = ~(a | b);
      4'h9: e.out = ~(a ^ b);
      4'hA: e.out = a << sh;
      4'hB: e.out = a >> sh;
      4'hC: e.out = (a << 1) | (a >> 7);
      4'hD: e.out = (a >> 1) | (a << 7);
      4'hE: e.out = (a > b) ? 8'h01 : 8'h00;
      default: e.out = a;
    endcase
    e.o = {6'b0, e.out == 8'h00, c};
    if (sel == 4'h2) begin
      p = 16'(a) * 16'(b);
      e.out = p[7:0];
      e.o = p[15:8];
      e.lat = 9;
    end else if (sel == 4'h3) begin
      e.out = (b == 8'h00) ? 8'hFF : a / b;
      e.o = (b == 8'h00) ? a : a % b;
      e.lat = 9;
    end
    return e;
  endfunction

  // Entered and left on a negedge; on return the accept edge has passed (we are in cycle 1).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input exp_t e, input bit push);
    int n;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_sel = sel;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("accept_timeout", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a = ~a;
    bus.req_b = ~b;
    bus.req_sel = ~sel;
    if (push) sb.push_back(e);
  endtask

  task automatic collect(input string nm);
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL %s: response with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_out"}, 32'(bus.rsp_out), 32'(e.out));
      chk({nm, "_o"}, 32'(bus.rsp_o), 32'(e.o));
      chk({nm, "_lat"}, 32'(lat), 32'(e.lat));
    end
    if (bus.rsp_ready) begin
      @(negedge clk);
      chk({nm, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
      chk({nm, "_rdy"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    int   seen;
    bus.req_valid = 1'b0;
    bus.req_a = 8'h00;
    bus.req_b = 8'h00;
    bus.req_sel = 4'h0;
    bus.rsp_ready = 1'b1;

    vecs.push_back('{4'h0, 8'h0A, 8'h02, 8'h0C, 8'h00, 1});
    vecs.push_back('{4'h1, 8'h0A, 8'h02, 8'h08, 8'h00, 1});
    vecs.push_back('{4'h2, 8'h0A, 8'h02, 8'h14, 8'h00, 9});
    vecs.push_back('{4'h3, 8'h0A, 8'h02, 8'h05, 8'h00, 9});
    vecs.push_back('{4'h4, 8'h0A, 8'h02, 8'h02, 8'h00, 1});
    vecs.push_back('{4'h5, 8'h0A, 8'h02, 8'h0A, 8'h00, 1});
    vecs.push_back('{4'h6, 8'h0A, 8'h02, 8'h08, 8'h00, 1});
    vecs.push_back('{4'h7, 8'h0A, 8'h02, 8'hFD, 8'h00, 1});
    vecs.push_back('{4'h8, 8'h0A, 8'h02, 8'hF5, 8'h00, 1});
    vecs.push_back('{4'h9, 8'h0A, 8'h02, 8'hF7, 8'h00, 1});
    vecs.push_back('{4'hA, 8'h0A, 8'h02, 8'h28, 8'h00, 1});
    vecs.push_back('{4'hB, 8'h0A, 8'h02, 8'h02, 8'h00, 1});
    vecs.push_back('{4'hC, 8'h0A, 8'h02, 8'h14, 8'h00, 1});
    vecs.push_back('{4'hD, 8'h0A, 8'h02, 8'h05, 8'h00, 1});
    vecs.push_back('{4'hE, 8'h0A, 8'h02, 8'h01, 8'h00, 1});
    vecs.push_back('{4'hF, 8'h0A, 8'h02, 8'h0A, 8'h00, 1});
    vecs.push_back('{4'h0, 8'hF6, 8'h0A, 8'h00, 8'h03, 1});
    vecs.push_back('{4'h1, 8'h02, 8'h0A, 8'hF8, 8'h01, 1});
    vecs.push_back('{4'h2, 8'hF6, 8'h0A, 8'h9C, 8'h09, 9});
    vecs.push_back('{4'h3, 8'hF6, 8'h0A, 8'h18, 8'h06, 9});
    vecs.push_back('{4'h3, 8'hF6, 8'h00, 8'hFF, 8'hF6, 9});
    vecs.push_back('{4'h4, 8'h0F, 8'hF0, 8'h00, 8'h02, 1});
    vecs.push_back('{4'hE, 8'h05, 8'h05, 8'h00, 8'h02, 1});

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out", 32'(bus.rsp_out), 32'd0);
    chk("rst_o", 32'(bus.rsp_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    foreach (vecs[i]) begin
      e.out = vecs[i].out;
      e.o = vecs[i].o;
      e.lat = vecs[i].lat;
      issue(vecs[i].a, vecs[i].b, vecs[i].sel, e, 1'b1);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      logic [7:0] a, b;
      logic [3:0] sel;
      a = 8'($urandom_range(0, 255));
      b = (i % 6 == 5) ? 8'h00 : 8'($urandom_range(0, 255));
      sel = 4'(i % 16);
      if (i >= 16) sel = (i % 2 == 0) ? 4'h2 : 4'h3;
      issue(a, b, sel, model(a, b, sel), 1'b1);
      collect($sformatf("rnd%0d", i));
    end

    // Backpressure: result must hold while a second request waits outside.
    bus.rsp_ready = 1'b0;
    issue(8'h33, 8'h11, 4'h0, model(8'h33, 8'h11, 4'h0), 1'b1);
    collect("bp_add");
    bus.req_a = 8'h0A;
    bus.req_b = 8'h02;
    bus.req_sel = 4'h1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), 32'({bus.rsp_out, bus.rsp_o}), 32'h4400);
      chk($sformatf("bp_ready%0d", i), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    e.out = 8'h08;
    e.o = 8'h00;
    e.lat = 1;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    collect("bp_sub");

    // Reset during MUL at cycle 4 aborts it without a response.
    issue(8'hF6, 8'h0A, 4'h2, e, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_out", 32'(bus.rsp_out), 32'd0);
    chk("abort_o", 32'(bus.rsp_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    issue(8'h0A, 8'h02, 4'h0, model(8'h0A, 8'h02, 4'h0), 1'b1);
    collect("post_rst_add");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/alu_resp.md
# alu_resp

Handshaked, registered ALU execution unit: accepts one operation request (operands A/B plus 4-bit select) over a valid/ready interface, computes it, and returns the result over a second valid/ready interface. It is the responder that the ALU stimulus side talks to. Single-cycle ops cover logic, add/sub, shifts and rotates; MUL and DIV run as iterative multi-cycle operations. One operation is in flight at a time.

## Interface
- WIDTH, 8, operand/result width; all widths below scale with it.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_sel  in  4  operation select
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_out  out  WIDTH  primary result
- rsp_o  out  WIDTH  secondary result: flags, MUL high half, or DIV remainder
- busy  out  1  high in CALC or RESP

## Operation
- Request accepted on a clock edge with req_valid && req_ready; req_a/req_b/req_sel are captured at that edge, so later changes have no effect.
- FSM states:
  - IDLE: req_ready=1. On accept, go to CALC if sel is 2 or 3, else RESP.
  - CALC: step counter 0..WIDTH-1. After WIDTH steps, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready=1, go to IDLE; otherwise hold.
- Single-cycle op result is registered at the accept edge.
- sel map:
  - 0 ADD: out=A+B; O[0]=carry out.
  - 1 SUB: out=A-B; O[0]=borrow (A<B).
  - 2 MUL: unsigned shift-add; {O,out}=A*B.
  - 3 DIV: unsigned restoring division; out=A/B, O=A%B. If B==0: out=all ones, O=A, with the same latency.
  - 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOR, 9 XNOR.
  - A SHL: A<<B[2:0].
  - B SHR (logical): A>>B[2:0].
  - C ROL by 1.
  - D ROR by 1.
  - E CMP: out=1 if A>B else 0.
  - F PASS: out=A.
- Flags for every op except MUL/DIV: O[1]=(out==0). O[0] is as defined for ADD/SUB and 0 for all others. Remaining O bits are 0.
- All arithmetic is unsigned and modulo 2^WIDTH; no overflow flag.
- rsp_out/rsp_o change only on the transition into RESP, and are held stable for all of RESP.

## Timing
- Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_out=0, rsp_o=0, busy=0, counter=0.
- While rst_n is low, requests are ignored.
- Reset asserted in CALC or RESP aborts the operation; no response is ever produced for it.
- Latency is counted from the accept edge (cycle 0):
  - single-cycle ops: rsp_valid=1 at cycle 1.
  - MUL/DIV: rsp_valid=1 at cycle WIDTH+1 (cycle 9 for WIDTH=8).
- RESP with rsp_ready=1 at edge t: rsp_valid=0 and req_ready=1 from t+1. A new request cannot be accepted at edge t.
- Maximum throughput: one single-cycle op per 2 cycles.
- rsp_ready may be held high permanently; rsp_valid then pulses for exactly 1 cycle.
- Backpressure: rsp_valid stays 1 and data is stable until the handshake; req_ready=0 throughout.
- req_valid while not IDLE: the request is not accepted. The requester must hold it until req_ready.
- busy = !req_ready.

## Test plan
- After reset: req_ready=1, all other outputs 0. Sweep sel 0..15 with A=0x0A, B=0x02 and rsp_ready=1. Required per op:
  - out values: 0x0C, 0x08, 0x14, 0x05, 0x02, 0x0A, 0x08, 0xFD, 0xF5, 0xF7, 0x28, 0x02, 0x14, 0x05, 0x01, 0x0A.
  - MUL: O=0x00. DIV: O=0x00.
  - SUB and AND: out 0x08/0x02, O[0]=0, O[1]=0.
  - Latency: 1 cycle, except MUL/DIV at 9 cycles.
- ADD A=0xF6, B=0x0A -> out=0x00, O=0x03 (carry and zero set).
- SUB A=0x02, B=0x0A -> out=0xF8, O=0x01.
- MUL A=0xF6, B=0x0A -> out=0x9C, O=0x09, rsp_valid 9 cycles after accept.
- DIV A=0xF6, B=0x0A -> out=0x18, O=0x06.
- DIV A=0xF6, B=0x00 -> out=0xFF, O=0xF6, 9-cycle latency.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0, a pending req_valid is not accepted. Release rsp_ready -> req_ready=1 the next cycle, and the held request is then accepted.
- Assert rst_n=0 at cycle 4 of a MUL -> all outputs return to reset values immediately and no rsp_valid appears. A following ADD (A=0x0A, B=0x02) works normally and returns out=0x0C.
